crank_wheel_gen: RTL and testbench



---
 rtl/crank_wheel_gen_pkg.sv | 14 +
 rtl/crank_wheel_gen_if.sv | 30 +++
 rtl/crank_wheel_gen_slot_timer.sv | 44 ++++
 rtl/crank_wheel_gen.sv | 114 +++++++++++
 tb/tb_crank_wheel_gen.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crank_wheel_gen_pkg.sv
// Shared constants and state type for the crank wheel generator and the HWAG receiver.
package crank_wheel_gen_pkg;

    localparam int HWAG_PCNT_WIDTH    = 24;
    localparam int HWAG_TCNT_WIDTH    = 6;
    localparam int HWAG_TEETH_TOTAL   = 60;
    localparam int HWAG_TEETH_MISSING = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_t;

endpackage

// File: rtl/crank_wheel_gen_if.sv
// Control and observation signals of the crank wheel generator.
interface crank_wheel_gen_if
    import crank_wheel_gen_pkg::*;
#(
    parameter int PER_WIDTH  = HWAG_PCNT_WIDTH,
    parameter int TCNT_WIDTH = HWAG_TCNT_WIDTH
);

    logic                  ena;
    logic [PER_WIDTH-1:0]  period;
    logic [TCNT_WIDTH-1:0] start_tooth;
    logic                  inv;
    logic                  cap;
    logic                  busy;
    logic [TCNT_WIDTH-1:0] tooth_num;
    logic                  gap;
    logic                  rev_pulse;
    logic                  period_err;

    modport master (
        output ena, period, start_tooth, inv,
        input  cap, busy, tooth_num, gap, rev_pulse, period_err
    );

    modport slave (
        input  ena, period, start_tooth, inv,
        output cap, busy, tooth_num, gap, rev_pulse, period_err
    );

endinterface

// File: rtl/crank_wheel_gen_slot_timer.sv
// Per-slot clock counter with a period shadow register that reloads only on slot boundaries.
module crank_wheel_gen_slot_timer #(
    parameter int PER_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic                 i_start,
    input  logic [PER_WIDTH-1:0] i_period,
    output logic                 o_boundary,
    output logic [PER_WIDTH-1:0] o_pcnt_nxt,
    output logic [PER_WIDTH-1:0] o_period_q_nxt
);

    logic [PER_WIDTH-1:0] r_pcnt;
    logic [PER_WIDTH-1:0] r_period_q;
    logic                 w_reload;

    assign o_boundary = i_run && (r_pcnt == (r_period_q - PER_WIDTH'(1)));
    assign w_reload   = i_start || o_boundary;

    // Next values are exported so the owner can register outputs aligned with the counter.
    always_comb begin
        o_pcnt_nxt     = r_pcnt;
        o_period_q_nxt = r_period_q;
        if (w_reload) begin
            o_pcnt_nxt     = '0;
            o_period_q_nxt = i_period;
        end else if (i_run) begin
            o_pcnt_nxt = r_pcnt + PER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt     <= '0;
            r_period_q <= '0;
        end else begin
            r_pcnt     <= o_pcnt_nxt;
            r_period_q <= o_period_q_nxt;
        end
    end

endmodule

// File: rtl/crank_wheel_gen.sv
// N-M toothed crank wheel emulator: programmable slot period, start slot and output polarity.
module crank_wheel_gen
    import crank_wheel_gen_pkg::*;
#(
    parameter int PER_WIDTH     = HWAG_PCNT_WIDTH,
    parameter int TCNT_WIDTH    = HWAG_TCNT_WIDTH,
    parameter int TEETH_TOTAL   = HWAG_TEETH_TOTAL,
    parameter int TEETH_MISSING = HWAG_TEETH_MISSING
) (
    input  logic              clk,
    input  logic              rst,
    crank_wheel_gen_if.slave  bus
);

    if (!((TEETH_MISSING < TEETH_TOTAL) && (TEETH_TOTAL <= (1 << TCNT_WIDTH)))) begin : g_bad_params
        $error("crank_wheel_gen: need TEETH_MISSING < TEETH_TOTAL <= 2**TCNT_WIDTH");
    end

    localparam logic [TCNT_WIDTH-1:0] L_FIRST_GAP = TCNT_WIDTH'(TEETH_TOTAL - TEETH_MISSING);
    localparam logic [TCNT_WIDTH-1:0] L_LAST_SLOT = TCNT_WIDTH'(TEETH_TOTAL - 1);
    localparam logic [TCNT_WIDTH:0]   L_SLOTS     = (TCNT_WIDTH + 1)'(TEETH_TOTAL);

    gen_state_t            r_state;
    gen_state_t            w_state_nxt;
    logic [TCNT_WIDTH-1:0] r_tcnt;
    logic [TCNT_WIDTH-1:0] w_tcnt_nxt;
    logic [TCNT_WIDTH-1:0] w_start_slot;
    logic                  r_cap;
    logic                  r_busy;
    logic                  r_gap;
    logic                  r_rev_pulse;
    logic                  r_period_err;
    logic                  w_run;
    logic                  w_run_nxt;
    logic                  w_period_ok;
    logic                  w_start;
    logic                  w_boundary;
    logic                  w_stop;
    logic                  w_advance;
    logic                  w_err_nxt;
    logic                  w_active;
    logic [PER_WIDTH-1:0]  w_pcnt_nxt;
    logic [PER_WIDTH-1:0]  w_period_q_nxt;

    assign w_run        = (r_state == RUN);
    assign w_period_ok  = (bus.period > PER_WIDTH'(1));
    assign w_start      = !w_run && bus.ena && w_period_ok;
    assign w_stop       = w_boundary && !(bus.ena && w_period_ok);
    assign w_advance    = w_boundary && !w_stop;
    assign w_start_slot = ({1'b0, bus.start_tooth} >= L_SLOTS) ? '0 : bus.start_tooth;

    crank_wheel_gen_slot_timer #(
        .PER_WIDTH (PER_WIDTH)
    ) u_slot_timer (
        .clk            (clk),
        .rst            (rst),
        .i_run          (w_run),
        .i_start        (w_start),
        .i_period       (bus.period),
        .o_boundary     (w_boundary),
        .o_pcnt_nxt     (w_pcnt_nxt),
        .o_period_q_nxt (w_period_q_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_err_nxt   = 1'b0;
        if (w_start) begin
            w_state_nxt = RUN;
            w_tcnt_nxt  = w_start_slot;
        end else if (!w_run && bus.ena) begin
            w_err_nxt = 1'b1;
        end else if (w_stop) begin
            // Stopping keeps the slot index so tooth_num shows where the wheel halted.
            w_state_nxt = IDLE;
            w_err_nxt   = !w_period_ok;
        end else if (w_advance) begin
            w_tcnt_nxt = (r_tcnt == L_LAST_SLOT) ? '0 : r_tcnt + TCNT_WIDTH'(1);
        end
    end

    assign w_run_nxt = (w_state_nxt == RUN);
    assign w_active  = w_run_nxt && (w_tcnt_nxt < L_FIRST_GAP) &&
                       (w_pcnt_nxt < (w_period_q_nxt >> 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tcnt       <= '0;
            r_cap        <= bus.inv;
            r_busy       <= 1'b0;
            r_gap        <= 1'b0;
            r_rev_pulse  <= 1'b0;
            r_period_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_cap        <= w_active ? ~bus.inv : bus.inv;
            r_busy       <= w_run_nxt;
            r_gap        <= w_run_nxt && (w_tcnt_nxt >= L_FIRST_GAP);
            r_rev_pulse  <= (w_start || w_advance) && (w_tcnt_nxt == '0);
            r_period_err <= w_err_nxt;
        end
    end

    assign bus.cap        = r_cap;
    assign bus.busy       = r_busy;
    assign bus.tooth_num  = r_tcnt;
    assign bus.gap        = r_gap;
    assign bus.rev_pulse  = r_rev_pulse;
    assign bus.period_err = r_period_err;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Self-checking bench for crank_wheel_gen: directed wheel-shape scenarios plus randomized model comparison.
module tb_crank_wheel_gen;

    localparam int PW = 24;
    localparam int TW = 6;
    localparam int NT = 60;
    localparam int NM = 2;

    logic clk = 1'b0;
    logic rst;

    crank_wheel_gen_if #(.PER_WIDTH(PW), .TCNT_WIDTH(TW)) bus ();

    crank_wheel_gen #(
        .PER_WIDTH     (PW),
        .TCNT_WIDTH    (TW),
        .TEETH_TOTAL   (NT),
        .TEETH_MISSING (NM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference wheel: running flag, slot index, clock position in slot, slot length.
    bit          m_run;
    int          m_pos;
    int          m_slot;
    int          m_per;
    logic [10:0] m_exp;

    task automatic model_step(input logic r, input logic e, input int p, input int st, input logic iv);
        bit err = 1'b0;
        bit rev = 1'b0;
        bit act;
        if (r) begin
            m_run = 1'b0; m_pos = 0; m_slot = 0; m_per = 0;
        end else if (!m_run) begin
            if (e && p >= 2) begin
                m_run = 1'b1; m_pos = 0; m_per = p;
                m_slot = (st >= NT) ? 0 : st;
                rev = (m_slot == 0);
            end else if (e) begin
                err = 1'b1;
            end
        end else if (m_pos == m_per - 1) begin
            if (p < 2) err = 1'b1;
            if (!e || p < 2) begin
                m_run = 1'b0; m_pos = 0;
            end else begin
                m_pos = 0; m_per = p; m_slot = (m_slot + 1) % NT;
                rev = (m_slot == 0);
            end
        end else begin
            m_pos++;
        end
        act = m_run && (m_slot < NT - NM) && (m_pos < m_per / 2);
        m_exp = {act ? ~iv : iv, m_run, m_run && (m_slot >= NT - NM), rev, err, TW'(m_slot)};
    endtask

    task automatic tick();
        model_step(rst, bus.ena, int'(bus.period), int'(bus.start_tooth), bus.inv);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [10:0] obs();
        return {bus.cap, bus.busy, bus.gap, bus.rev_pulse, bus.period_err, bus.tooth_num};
    endfunction

    task automatic test_reset();
        rst = 1'b1; bus.ena = 1'b0; bus.period = PW'(10); bus.start_tooth = '0; bus.inv = 1'b0;
        tick(); tick();
        checks++;
        if (obs() !== 11'b0) begin
            errors++; $display("FAIL reset_state got %b exp %b", obs(), 11'b0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== m_exp) begin
            errors++; $display("FAIL reset_idle cyc %0d got %b exp %b", cyc, obs(), m_exp);
        end
    endtask

    task automatic test_basic_wheel();
        int   rises = 0, hi_run = 0, bad_hi = 0, revs = 0, gaps = 0, last57 = -1, gap_to0 = -1, n = 0;
        logic prev = 1'b0;
        bus.period = PW'(10); bus.start_tooth = '0; bus.inv = 1'b0; bus.ena = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            tick();
            checks++;
            if (obs() !== m_exp) begin
                errors++; $display("FAIL basic_model cyc %0d got %b exp %b", cyc, obs(), m_exp);
            end
            if (bus.cap && !prev) begin
                if (i < 600) rises++;
                if (bus.tooth_num == TW'(57) && last57 < 0) last57 = i;
                if (bus.tooth_num == '0 && last57 >= 0 && gap_to0 < 0) gap_to0 = i - last57;
            end
            if (bus.cap) hi_run++;
            else if (prev) begin
                if (hi_run != 5) bad_hi++;
                hi_run = 0;
            end
            if (bus.rev_pulse) revs++;
            if (i < 600 && bus.gap) gaps++;
            prev = bus.cap;
        end
        checks += 5;
        if (rises != 58)   begin errors++; $display("FAIL basic_rises got %0d exp 58", rises); end
        if (bad_hi != 0)   begin errors++; $display("FAIL basic_high_width got %0d bad exp 0", bad_hi); end
        if (gap_to0 != 30) begin errors++; $display("FAIL basic_gap_span got %0d exp 30", gap_to0); end
        if (revs != 2)     begin errors++; $display("FAIL basic_rev_pulses got %0d exp 2", revs); end
        if (gaps != 20)    begin errors++; $display("FAIL basic_gap_clocks got %0d exp 20", gaps); end
        bus.ena = 1'b0;
        while (bus.busy && n < 40) begin tick(); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_drain busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_period_change();
        int n = 0, s5 = 4, s6 = 0, hi6 = 0;
        bus.period = PW'(10); bus.start_tooth = '0; bus.inv = 1'b0; bus.ena = 1'b1;
        do begin
            tick(); n++;
            checks++;
            if (obs() !== m_exp) begin
                errors++; $display("FAIL pchg_model cyc %0d got %b exp %b", cyc, obs(), m_exp);
            end
        end while (bus.tooth_num != TW'(5) && n < 100);
        tick(); tick(); tick();
        bus.period = PW'(20);
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (obs() !== m_exp) begin
                errors++; $display("FAIL pchg_model cyc %0d got %b exp %b", cyc, obs(), m_exp);
            end
            if (bus.tooth_num == TW'(5)) s5++;
            else if (bus.tooth_num == TW'(6)) begin s6++; if (bus.cap) hi6++; end
            else break;
        end
        checks += 3;
        if (s5 != 10)  begin errors++; $display("FAIL pchg_slot5_len got %0d exp 10", s5); end
        if (s6 != 20)  begin errors++; $display("FAIL pchg_slot6_len got %0d exp 20", s6); end
        if (hi6 != 10) begin errors++; $display("FAIL pchg_slot6_high got %0d exp 10", hi6); end
        bus.ena = 1'b0;
        n = 0;
        while (bus.busy && n < 60) begin tick(); n++; end
        bus.period = PW'(10);
    endtask

    task automatic test_ena_drop();
        int n = 0;
        bus.period = PW'(10); bus.start_tooth = '0; bus.inv = 1'b0; bus.ena = 1'b1;
        do begin tick(); n++; end while (bus.tooth_num != TW'(7) && n < 200);
        tick(); tick();
        bus.ena = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            checks++;
            if (obs() !== m_exp) begin
                errors++; $display("FAIL drop_model cyc %0d got %b exp %b", cyc, obs(), m_exp);
            end
            if (!bus.busy) break;
        end
        checks++;
        if (n != 8 || bus.cap !== 1'b0 || bus.tooth_num !== TW'(7)) begin
            errors++;
            $display("FAIL drop_complete got clocks %0d cap %b tooth %0d exp 8 0 7", n, bus.cap, bus.tooth_num);
        end
    endtask

    task automatic test_period_err();
        int n = 0, errs = 0;
        bus.period = PW'(1); bus.start_tooth = '0; bus.inv = 1'b0; bus.ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.period_err, bus.busy, bus.cap} !== 3'b100) begin
                errors++;
                $display("FAIL perr_idle err/busy/cap got %b exp 100", {bus.period_err, bus.busy, bus.cap});
            end
        end
        bus.period = PW'(10);
        tick();
        bus.period = '0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            checks++;
            if (obs() !== m_exp) begin
                errors++; $display("FAIL perr_model cyc %0d got %b exp %b", cyc, obs(), m_exp);
            end
            if (bus.period_err) errs++;
            if (!bus.busy) break;
        end
        bus.ena = 1'b0;
        tick();
        checks++;
        if (n != 10 || errs != 1 || bus.period_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_run_boundary got clocks %0d pulses %0d err %b exp 10 1 0", n, errs, bus.period_err);
        end
        bus.period = PW'(10);
    endtask

    task automatic test_rst_mid();
        int n = 0;
        bus.period = PW'(10); bus.start_tooth = TW'(28); bus.inv = 1'b0; bus.ena = 1'b1;
        do begin tick(); n++; end while (bus.tooth_num != TW'(30) && n < 100);
        tick();
        checks++;
        if (bus.cap !== 1'b1) begin errors++; $display("FAIL rstmid_high got %b exp 1", bus.cap); end
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== 11'b0) begin errors++; $display("FAIL rstmid_state got %b exp %b", obs(), 11'b0); end
        rst = 1'b0; bus.ena = 1'b0;
        tick();
        checks++;
        if (obs() !== m_exp) begin errors++; $display("FAIL rstmid_after got %b exp %b", obs(), m_exp); end
    endtask

    task automatic test_start_58();
        int n = 0;
        bus.period = PW'(10); bus.start_tooth = TW'(58); bus.inv = 1'b0; bus.ena = 1'b1;
        tick();
        checks++;
        if ({bus.gap, bus.cap, bus.rev_pulse, bus.tooth_num} !== {3'b100, TW'(58)}) begin
            errors++;
            $display("FAIL start58_first got gap %b cap %b rev %b tooth %0d exp 1 0 0 58",
                     bus.gap, bus.cap, bus.rev_pulse, bus.tooth_num);
        end
        while (!bus.cap && n < 40) begin
            tick(); n++;
            checks++;
            if (obs() !== m_exp) begin
                errors++; $display("FAIL start58_model cyc %0d got %b exp %b", cyc, obs(), m_exp);
            end
        end
        checks++;
        if (n != 20 || bus.rev_pulse !== 1'b1 || bus.tooth_num !== '0) begin
            errors++;
            $display("FAIL start58_edge got clocks %0d rev %b tooth %0d exp 20 1 0", n, bus.rev_pulse, bus.tooth_num);
        end
        bus.ena = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin tick(); n++; end
    endtask

    task automatic test_inv();
        int   n = 0;
        logic plain;
        bus.inv = 1'b1; bus.ena = 1'b0;
        tick();
        checks++;
        if (bus.cap !== 1'b1) begin errors++; $display("FAIL inv_idle got %b exp 1", bus.cap); end
        bus.period = PW'(10); bus.start_tooth = '0; bus.ena = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            plain = ((i / 10) < 58) && ((i % 10) < 5);
            checks++;
            if (bus.cap !== ~plain || obs() !== m_exp) begin
                errors++; $display("FAIL inv_wave cyc %0d got %b exp cap %b model %b", cyc, obs(), ~plain, m_exp);
            end
        end
        bus.ena = 1'b0;
        while (bus.busy && n < 20) begin tick(); n++; end
        bus.inv = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) bus.ena = ~bus.ena;
            if ($urandom_range(0, 29) == 0) bus.period = PW'($urandom_range(2, 12));
            if ($urandom_range(0, 199) == 0) bus.period = PW'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) bus.start_tooth = TW'($urandom_range(0, 63));
            if ($urandom_range(0, 299) == 0) bus.inv = ~bus.inv;
            tick();
            checks++;
            if (obs() !== m_exp) begin
                errors++; $display("FAIL random_model cyc %0d got %b exp %b", cyc, obs(), m_exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.period = PW'(10);
        bus.start_tooth = '0;
        bus.inv = 1'b0;
        test_reset();
        test_basic_wheel();
        test_period_change();
        test_ena_drop();
        test_period_err();
        test_rst_mid();
        test_start_58();
        test_inv();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
